// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the multiply-sequencer state type.
package alu_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_PASSB = 3'b100;
    localparam logic [2:0] ALUOP_LSL   = 3'b101;
    localparam logic [2:0] ALUOP_LSR   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Shift-and-add 64-bit MUL sequencer that borrows the shared execute-stage ALU for each add.
// Optional macro MUL_SEQ_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
//
// state | meaning
// IDLE  | waiting for start; ALU not requested
// RUN   | one shift-and-add step per cycle through the shared ALU
// DONE  | one-cycle done pulse; product valid
module mul_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product,
    output logic            alu_req,
    output logic [XLEN-1:0] alu_op_A,
    output logic [XLEN-1:0] alu_op_B,
    output logic [2:0]      alu_aluop,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    mul_state_t      state_q,   state_d;
    logic [XLEN-1:0] mcand_q,   mcand_d;
    logic [XLEN-1:0] mplier_q,  mplier_d;
    logic [XLEN-1:0] acc_q,     acc_d;
    logic [XLEN-1:0] product_q, product_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic            last_step;

    always_comb begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
        last_step = (cnt_q == CNT_LAST) || ((mplier_q >> 1) == '0);
`else
        last_step = (cnt_q == CNT_LAST);
`endif
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        done      = 1'b0;
        alu_req   = 1'b0;
        alu_op_A  = '0;
        alu_op_B  = '0;
        alu_aluop = ALUOP_ADD;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                busy     = 1'b1;
                alu_req  = 1'b1;
                alu_op_A = acc_q;
                alu_op_B = mplier_q[0] ? mcand_q : '0;
                acc_d    = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_step) begin
                    state_d   = DONE;
                    product_d = alu_result;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    assign product = product_q;

endmodule
